usb_ep_in_source: RTL

USB_EP_IN_SOURCE -- requirements
Module: usb_ep_in_source

---
 rtl/usb_pkg.sv | 21 ++
 rtl/usb_pkt_buf.sv | 30 +++
 rtl/usb_ep_in_source.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB IN endpoint source: handshake codes,
// endpoint state encoding and a buffer address-width helper.
package usb_pkg;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NAK   = 2'b01;
   localparam logic [1:0] HS_STALL = 2'b10;
   // 2'b11 is reserved

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_READY = 2'd1,
      ST_SEND  = 2'd2
   } ep_state_t;

   // Address bits needed for an n-entry buffer (at least one bit)
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usb_pkt_buf.sv
// Packet byte store: one synchronous write port, one asynchronous read port.
// No reset: the contents are only meaningful below the committed length.
module usb_pkt_buf
   import usb_pkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic                         clk48,
   input  logic                         wr_en_i,
   input  logic [addr_w(MAX_PKT)-1:0]   waddr_i,
   input  logic [7:0]                   wdata_i,
   input  logic [addr_w(MAX_PKT)-1:0]   raddr_i,
   output logic [7:0]                   rdata_o
);

   localparam int AW    = addr_w(MAX_PKT);
   localparam int DEPTH = 1 << AW;

   logic [7:0] mem_q [DEPTH];

   // Store one byte per accepted write
   always_ff @(posedge clk48) begin
      if (wr_en_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_ep_in_source.sv
// USB IN endpoint data source: collects bytes from the local side into a
// single packet buffer, then serves that packet to the USB core on IN
// transactions, tracking the DATA0/DATA1 toggle and retrying on failure.
module usb_ep_in_source
   import usb_pkg::*;
#(
   parameter logic [3:0] EP_NUM  = 4'd1,
   parameter int         MAX_PKT = 8
) (
   input  logic       clk48,
   input  logic       rst,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_commit,
   input  logic       stall,
   input  logic       usb_rst,
   input  logic       transaction_active,
   input  logic       direction_in,
   input  logic       setup,
   input  logic       data_strobe,
   input  logic       success,
   input  logic [3:0] endpoint,
   output logic [7:0] data_in,
   output logic       data_in_valid,
   output logic [1:0] handshake,
   output logic       data_toggle,
   output logic       pkt_sent
);

   localparam int         AW   = addr_w(MAX_PKT);
   localparam logic [6:0] MAXC = 7'(MAX_PKT);

   ep_state_t  state_q;
   logic [6:0] wcnt_q;
   logic [6:0] rptr_q;
   logic [6:0] plen_q;
   logic       toggle_q;
   logic       pkt_sent_q;
   logic       match_q;
   logic       active_q;

   logic       match;
   logic       match_rise;
   logic       active_fall;
   logic       setup_hit;
   logic       wr_accept;
   logic [7:0] rd_byte;

   assign match       = transaction_active && direction_in && (endpoint == EP_NUM);
   assign match_rise  = match && !match_q;
   assign active_fall = !transaction_active && active_q;
   assign setup_hit   = setup && transaction_active && (endpoint == EP_NUM);

   assign wr_ready  = (state_q == ST_FILL) && (wcnt_q < MAXC);
   assign wr_accept = wr_valid && wr_ready;

   usb_pkt_buf #(
      .MAX_PKT (MAX_PKT)
   ) u_buf (
      .clk48   (clk48),
      .wr_en_i (wr_accept),
      .waddr_i (wcnt_q[AW-1:0]),
      .wdata_i (wr_data),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (rd_byte)
   );

   assign data_in_valid = (state_q == ST_SEND) && (rptr_q < plen_q);
   assign data_in       = (state_q == ST_SEND) ? rd_byte : 8'h00;
   assign data_toggle   = toggle_q;
   assign pkt_sent      = pkt_sent_q;

   // Handshake answer: STALL overrides, ACK whenever a packet is committed
   always_comb begin
      handshake = HS_NAK;
      if (stall) begin
         handshake = HS_STALL;
      end else if (state_q != ST_FILL) begin
         handshake = HS_ACK;
      end
   end

   // Endpoint state machine: fill, wait for IN, send, then complete or retry
   always_ff @(posedge clk48) begin
      if (rst || usb_rst) begin
         state_q    <= ST_FILL;
         wcnt_q     <= 7'd0;
         rptr_q     <= 7'd0;
         plen_q     <= 7'd0;
         toggle_q   <= 1'b0;
         pkt_sent_q <= 1'b0;
         match_q    <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         match_q    <= match;
         active_q   <= transaction_active;
         pkt_sent_q <= 1'b0;

         if (setup_hit) begin
            toggle_q <= 1'b1;
         end

         case (state_q)
            ST_FILL: begin
               if (wr_accept) begin
                  wcnt_q <= wcnt_q + 7'd1;
               end
               if (wr_commit) begin
                  // a byte accepted alongside the commit belongs to this packet
                  plen_q  <= wr_accept ? (wcnt_q + 7'd1) : wcnt_q;
                  rptr_q  <= 7'd0;
                  state_q <= ST_READY;
               end
            end
            ST_READY: begin
               // a transaction that opens while stalled never starts sending
               if (match_rise && !stall) begin
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (data_strobe && (rptr_q < plen_q)) begin
                  rptr_q <= rptr_q + 7'd1;
               end
               if (active_fall) begin
                  if (success) begin
                     toggle_q   <= ~toggle_q;
                     pkt_sent_q <= 1'b1;
                     wcnt_q     <= 7'd0;
                     state_q    <= ST_FILL;
                  end else begin
                     // host did not acknowledge: rewind and offer the same packet
                     rptr_q  <= 7'd0;
                     state_q <= ST_READY;
                  end
               end
            end
            default: begin
               state_q <= ST_FILL;
            end
         endcase
      end
   end

endmodule
